// File: rtl/alu_pkg.sv
// Shared definitions for the operand-mux arbiter: FSM state codes,
// output-source tags and the default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // FSM state codes
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_A = 2'd1;
    localparam logic [1:0] SERVE_B = 2'd2;

    // Source tags carried on out_src and used as the prio value
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Map a requester tag to the state that serves it
    function automatic logic [1:0] serve_state(input logic src);
        return (src == SRC_B) ? SERVE_B : SERVE_A;
    endfunction

endpackage

// File: rtl/MUX_32_16.sv
// 2:1 operand mux cell shared by the two requesters: s = 0 passes a, s = 1 passes b.
module MUX_32_16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] c
);

    assign c = s ? b : a;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter with burst lock for the shared ALU operand mux.
// Two valid/ready requesters compete for the mux; the granted side keeps the
// mux until it sends a last beat or reaches MAX_BURST beats. Accepted beats
// land in a registered output stage with its own valid/ready handshake.
module mux16_rr_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    logic [1:0]       state_q, state_d;
    logic             prio_q, prio_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;

    logic [WIDTH-1:0] mux_c;
    logic             can_load;
    logic             accept;
    logic             cur_last;
    logic             other_valid;
    logic             grant_end;

    MUX_32_16 #(
        .W (WIDTH)
    ) u_mux (
        .a (a_data),
        .b (b_data),
        .s (sel),
        .c (mux_c)
    );

    // The output register can take a new beat when it is empty or draining now
    assign can_load = !out_valid_q || out_ready;

    assign sel     = (state_q == SERVE_B) ? SRC_B : SRC_A;
    assign a_ready = (state_q == SERVE_A) && can_load;
    assign b_ready = (state_q == SERVE_B) && can_load;
    assign busy    = (state_q != IDLE);

    assign accept      = (a_valid && a_ready) || (b_valid && b_ready);
    assign cur_last    = sel ? b_last  : a_last;
    assign other_valid = sel ? a_valid : b_valid;
    // The grant ends on a last beat or on the MAX_BURST-th beat, whichever comes first
    assign grant_end   = accept && (cur_last || (cnt_q == CNT_LAST));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    // Next-state logic: arbitration, burst lock/release and output register load/drain
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (a_valid && (!b_valid || (prio_q == SRC_A))) begin
                    state_d = SERVE_A;
                end else if (b_valid) begin
                    state_d = SERVE_B;
                end
            end
            SERVE_A, SERVE_B: begin
                if (grant_end) begin
                    // Hand priority over; switch straight to the other side if it waits
                    prio_d  = ~sel;
                    state_d = other_valid ? serve_state(~sel) : IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_c;
            out_src_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, counter, priority and output registers; reset drops any beat in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= SRC_A;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_A;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Shares one 16-bit 2:1 operand mux between two requesters, A and B, and drives its select line.
- Each requester uses a valid/ready handshake and may send multi-beat bursts marked with a last flag.
- Round-robin grant with burst lock; a registered output stage feeds the ALU operand input through a valid/ready handshake.
- Sits between the operand sources and the ALU datapath.

Parameters:
- WIDTH, 16: data width of both inputs and the output.
- MAX_BURST, 4: maximum beats per grant; the grant is forcibly released after this many beats.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A has a beat
- a_data  input  WIDTH  requester A data
- a_last  input  1  final beat of A's burst
- a_ready  output  1  A beat accepted this cycle when a_valid is also high
- b_valid  input  1  requester B has a beat
- b_data  input  WIDTH  requester B data
- b_last  input  1  final beat of B's burst
- b_ready  output  1  B beat accepted this cycle when b_valid is also high
- out_valid  output  1  out_data holds a beat
- out_data  output  WIDTH  registered mux output
- out_src  output  1  source of the current output beat: 0 = A, 1 = B
- out_ready  input  1  downstream accepts the beat
- sel  output  1  mux select: 0 passes A, 1 passes B
- busy  output  1  a grant is active (state is not IDLE)

Behaviour:
- Reset (asynchronous, active-high) clears everything regardless of state:
  - state = IDLE, prio = A, beat count = 0.
  - out_valid = 0, out_data = 0, out_src = 0.
  - sel = 0, a_ready = 0, b_ready = 0, busy = 0.
  - A beat in flight is discarded; no partial burst resumes after reset.
- States:
  - IDLE: sel = 0, no ready asserted.
  - SERVE_A: sel = 0.
  - SERVE_B: sel = 1.
- Arbitration in IDLE:
  - Only A valid → SERVE_A.
  - Only B valid → SERVE_B.
  - Both valid → the side named by prio.
  - Neither valid → stay in IDLE.
  - Arbitration costs one cycle; the first beat can be accepted no earlier than the cycle after a valid is seen in IDLE.
- Ready rule: x_ready = (state == SERVE_x) && (!out_valid || out_ready). The ready of the non-granted side is always 0.
- Accept: a beat transfers when x_valid && x_ready. On the next edge:
  - out_data = mux output; out_valid = 1; out_src = sel.
  - Latency from accept to out_valid is exactly 1 cycle.
- Output hold and drain:
  - While out_valid && !out_ready, out_data and out_src stay stable and no beat is accepted.
  - Drain with no new accept: out_valid goes to 0 on the edge where out_ready is high.
  - Simultaneous drain and accept: the register reloads and out_valid stays 1.
- Beat counter:
  - Counts accepted beats in the current grant.
  - Resets to 0 on every grant change and on IDLE entry.
  - Width is clog2(MAX_BURST) + 1.
- End of grant: the accepted beat has x_last = 1, or it is beat number MAX_BURST (count == MAX_BURST-1).
  - prio is set to the other side.
  - Next state is SERVE_other if the other side's valid is high that cycle, otherwise IDLE. There is no bubble on a direct switch.
- Burst lock:
  - Mid-burst (no last, count below the limit), the grant is held even if x_valid drops.
  - The other requester waits; no timeout.
- Forced release at MAX_BURST: the requester's remaining beats re-arbitrate as a new burst.
- busy = (state != IDLE).
- Requesters must hold valid and data until accepted; the block does not check this.

Decomposition:
- Shared package (alu_pkg): state encodings (IDLE = 2'd0, SERVE_A = 2'd1, SERVE_B = 2'd2), the SRC_A/SRC_B constants, and the default WIDTH.
- Sub-module: the existing 16-bit 2:1 mux cell (MUX_32_16), with a = a_data, b = b_data, s = sel, c = mux output.
- The FSM, beat counter, prio register and output register stay in this module.

Test Plan:
- Reset mid-burst: A granted, 2 beats accepted, assert rst for 1 cycle → all outputs 0 immediately; after release with a_valid high, IDLE, then SERVE_A again and the count restarts.
- Single requester: A sends 0x1234 then 0xBEEF (last), out_ready = 1 → out_data 0x1234 then 0xBEEF on consecutive cycles, out_src = 0, sel = 0; then IDLE.
- Contention round-robin: both valid, single-beat bursts (last = 1) → grants alternate A, B, A, B with no idle cycle between; out_src sequence 0, 1, 0, 1.
- Burst limit: B sends 6 beats 0x0001..0x0006, last only on the 6th, A idle → beats 1-4 in SERVE_B, then IDLE, re-grant to B, beats 5-6; with A valid at beat 4, A is served before beats 5-6.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 and out_data = 0x00FF → out_data stable, a_ready = 0; on out_ready = 1, the next beat loads in the same cycle.
- Lock hold: A mid-burst drops a_valid for 2 cycles while b_valid = 1 → b_ready stays 0 and sel stays 0 until A's last beat is accepted.
